// File: rtl/hilo_divider_if.sv
`default_nettype none
// ============================================================================
//  Module   : hilo_divider_if
//  Purpose  : Handshake bundle between the EX-stage controller and the HI/LO
//             divider. It carries the divide request, the cancel/flush input,
//             the stall output and the HI/LO write-back bundle.
//  Ports    : start, is_signed, dividend, divisor, cancel  (request side)
//             busy, hl_write_enable, hl_data                (response side)
//  Modports : master - the pipeline drives requests.
//             slave  - the divider answers them.
//  Revision : 1.0 - initial release
// ============================================================================
interface hilo_divider_if #(
    parameter int WIDTH = 32
);
    logic                   start;
    logic                   is_signed;
    logic [WIDTH-1:0]       dividend;
    logic [WIDTH-1:0]       divisor;
    logic                   cancel;
    logic                   busy;
    logic                   hl_write_enable;
    logic [2*WIDTH-1:0]     hl_data;

    modport master (
        output start, is_signed, dividend, divisor, cancel,
        input  busy, hl_write_enable, hl_data
    );

    modport slave (
        input  start, is_signed, dividend, divisor, cancel,
        output busy, hl_write_enable, hl_data
    );
endinterface
`default_nettype wire

// File: rtl/hilo_divider.sv
`default_nettype none
// ============================================================================
//  Module   : hilo_divider
//  Purpose  : Iterative radix-2 restoring divider for MIPS DIV/DIVU. It takes
//             WIDTH cycles in RUN, then spends one DONE cycle pulsing
//             hl_write_enable with {remainder, quotient}.
//  Ports    : clk  - rising-edge clock
//             rst  - asynchronous, active-low reset
//             bus  - hilo_divider_if.slave (request / stall / write-back)
//  Revision : 1.0 - initial release
// ============================================================================
module hilo_divider #(
    parameter int WIDTH = 32
) (
    input  wire logic       clk,
    input  wire logic       rst,
    hilo_divider_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [CW-1:0]          cnt_q;
    logic [WIDTH-1:0]       rem_q;      // partial remainder
    logic [WIDTH-1:0]       quo_q;      // dividend bits shifting out, quotient bits in
    logic [WIDTH-1:0]       dsr_q;      // divisor magnitude
    logic                   signed_q;
    logic                   sa_q;       // dividend sign bit
    logic                   sb_q;       // divisor sign bit
    logic [2*WIDTH-1:0]     hl_data_q;

    logic                   w_accept;
    logic                   w_last;
    logic [WIDTH:0]         w_shift;
    logic                   w_borrow;
    logic [WIDTH-1:0]       w_diff;
    logic [WIDTH-1:0]       w_rem_step;
    logic [WIDTH-1:0]       w_quo_step;
    logic [WIDTH-1:0]       w_rem_fix;
    logic [WIDTH-1:0]       w_quo_fix;

    assign w_accept = (state_q == S_IDLE) && bus.start && !bus.cancel;
    assign w_last   = (state_q == S_RUN) && (cnt_q == CW'(WIDTH - 1));

    // One restoring step. The shifted remainder is WIDTH+1 bits wide. When
    // no borrow occurs, the true difference is below the divisor, so the low
    // WIDTH bits of the difference are exact.
    assign w_shift    = {rem_q, quo_q[WIDTH-1]};
    assign w_borrow   = (w_shift < {1'b0, dsr_q});
    assign w_diff     = w_shift[WIDTH-1:0] - dsr_q;
    assign w_rem_step = w_borrow ? w_shift[WIDTH-1:0] : w_diff;
    assign w_quo_step = {quo_q[WIDTH-2:0], ~w_borrow};

    // Sign fix-up works on the result of the final step, so that result is
    // captured at the edge entering DONE. With a zero divisor the trial
    // subtract never borrows. The remainder therefore ends up as the dividend
    // magnitude, and re-applying the dividend sign restores the raw dividend.
    // Only the quotient needs the explicit all-ones override.
    assign w_quo_fix = (dsr_q == '0)              ? '1 :
                       (signed_q && (sa_q ^ sb_q)) ? -w_quo_step : w_quo_step;
    assign w_rem_fix = (signed_q && sa_q)         ? -w_rem_step : w_rem_step;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (w_accept) state_d = S_RUN;
            S_RUN:   if (bus.cancel) state_d = S_IDLE;
                     else if (w_last) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode. Cancel kills the write pulse within the same cycle.
    always_comb begin
        bus.busy            = (state_q != S_IDLE);
        bus.hl_write_enable = (state_q == S_DONE) && !bus.cancel;
    end

    assign bus.hl_data = hl_data_q;

    // Datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dsr_q     <= '0;
            signed_q  <= 1'b0;
            sa_q      <= 1'b0;
            sb_q      <= 1'b0;
            hl_data_q <= '0;
        end else if (w_accept) begin
            signed_q <= bus.is_signed;
            sa_q     <= bus.dividend[WIDTH-1];
            sb_q     <= bus.divisor[WIDTH-1];
            quo_q    <= (bus.is_signed && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
            dsr_q    <= (bus.is_signed && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;
            rem_q    <= '0;
            cnt_q    <= '0;
        end else if (state_q == S_RUN && !bus.cancel) begin
            rem_q <= w_rem_step;
            quo_q <= w_quo_step;
            cnt_q <= cnt_q + 1'b1;
            if (w_last) begin
                hl_data_q <= {w_rem_fix, w_quo_fix};
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_hilo_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hilo_divider
//  Purpose  : Self-checking bench for hilo_divider. It runs directed corner
//             cases, cancel/reset scenarios and randomized divides against a
//             plain-arithmetic reference.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hilo_divider;
    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    int   we_pulses = 0;
    logic [63:0] last_hl = '0;

    always #5 clk = ~clk;

    hilo_divider_if #(.WIDTH(32)) bus ();

    hilo_divider #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    // Every rising edge that sees the write enable high counts as a delivered pulse.
    always @(posedge clk) if (bus.hl_write_enable === 1'b1) we_pulses++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    // MIPS semantics: truncating division, remainder takes the dividend sign.
    // A zero divisor gives an all-ones quotient and the raw dividend as remainder.
    function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
        longint na, nb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            na = longint'($signed(a));
            nb = longint'($signed(b));
        end else begin
            na = longint'({32'd0, a});
            nb = longint'({32'd0, b});
        end
        q = na / nb;
        r = na % nb;
        return {r[31:0], q[31:0]};
    endfunction

    // Called at a negedge. Drives start immediately, so consecutive calls run back-to-back.
    task automatic run_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                           input bit poke, input string tag);
        logic [63:0] exp;
        int n;
        int busy_cnt;
        exp = ref_div(s, a, b);
        bus.start = 1'b1; bus.is_signed = s; bus.dividend = a; bus.divisor = b;
        @(negedge clk);
        bus.start = 1'b0;
        n = 1;
        busy_cnt = 0;
        while (bus.hl_write_enable !== 1'b1 && n < 100) begin
            if (bus.busy === 1'b1) busy_cnt++;
            if (poke && (n == 5 || n == 10)) begin
                bus.start = 1'b1; bus.is_signed = ~s;
                bus.dividend = $urandom; bus.divisor = $urandom;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0;
        if (bus.busy === 1'b1) busy_cnt++;
        check({tag, " latency"}, 64'(n), 64'd33);
        check({tag, " busy_cycles"}, 64'(busy_cnt), 64'd33);
        check({tag, " data"}, bus.hl_data, exp);
        @(negedge clk);
        check({tag, " pulse_end"}, {62'd0, bus.busy, bus.hl_write_enable}, 64'd0);
        check({tag, " hold"}, bus.hl_data, exp);
        last_hl = exp;
    endtask

    initial begin
        int pulses0;
        logic [31:0] ra, rb;
        bit rs;

        rst_n = 1'b0;
        bus.start = 1'b0; bus.is_signed = 1'b0; bus.dividend = '0; bus.divisor = '0; bus.cancel = 1'b0;
        #12;
        check("reset_state", {bus.busy, bus.hl_write_enable, bus.hl_data}, 66'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors, issued back-to-back
        run_div(1'b0, 32'd100, 32'd7, 1'b0, "divu_100_7");
        check("divu_100_7 lit", bus.hl_data, 64'h00000002_0000000E);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_m7_2");
        check("div_m7_2 lit", bus.hl_data, 64'hFFFFFFFF_FFFFFFFD);
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0, "div_7_m2");
        check("div_7_m2 lit", bus.hl_data, 64'h00000001_FFFFFFFD);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
        check("div_ovf lit", bus.hl_data, 64'h00000000_80000000);
        run_div(1'b0, 32'd5, 32'd0, 1'b0, "divu_5_0");
        check("divu_5_0 lit", bus.hl_data, 64'h00000005_FFFFFFFF);
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, "divu_max_1");
        check("divu_max_1 lit", bus.hl_data, 64'h00000000_FFFFFFFF);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd0, 1'b0, "div_m7_0");
        check("div_m7_0 lit", bus.hl_data, 64'hFFFFFFF9_FFFFFFFF);

        // start pulses while busy must be ignored
        run_div(1'b1, 32'h1234_5678, 32'hFFFF_FF00, 1'b1, "poke_busy");

        // cancel on RUN cycle 10
        pulses0 = we_pulses;
        bus.start = 1'b1; bus.is_signed = 1'b0; bus.dividend = 32'd1000; bus.divisor = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.cancel = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
        check("cancel_run busy", {63'd0, bus.busy}, 64'd0);
        repeat (30) @(negedge clk);
        check("cancel_run no_pulse", 64'(we_pulses - pulses0), 64'd0);
        check("cancel_run hl_hold", bus.hl_data, last_hl);

        // cancel during DONE
        pulses0 = we_pulses;
        bus.start = 1'b1; bus.is_signed = 1'b0; bus.dividend = 32'd77; bus.divisor = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (31) @(negedge clk);
        @(posedge clk);
        #1 bus.cancel = 1'b1;
        #1 check("cancel_done state", {62'd0, bus.busy, bus.hl_write_enable}, 64'd2);
        @(posedge clk);
        #1 bus.cancel = 1'b0;
        check("cancel_done busy", {63'd0, bus.busy}, 64'd0);
        check("cancel_done no_pulse", 64'(we_pulses - pulses0), 64'd0);
        @(negedge clk);

        // start together with cancel in IDLE is dropped
        bus.start = 1'b1; bus.cancel = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.cancel = 1'b0;
        check("start_cancel idle", {63'd0, bus.busy}, 64'd0);
        @(negedge clk);
        check("start_cancel idle2", {63'd0, bus.busy}, 64'd0);

        run_div(1'b0, 32'd200, 32'd9, 1'b0, "after_cancel");

        // asynchronous reset in mid-RUN
        bus.start = 1'b1; bus.is_signed = 1'b1; bus.dividend = 32'hDEAD_BEEF; bus.divisor = 32'd13;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (11) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset", {bus.busy, bus.hl_write_enable, bus.hl_data}, 66'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_div(1'b0, 32'd9, 32'd3, 1'b0, "post_reset");
        check("post_reset lit", bus.hl_data, 64'h00000000_00000003);

        // randomized divides
        for (int i = 0; i < 24; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 4))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = -32'($urandom_range(1, 15));
                3:       rb = ra >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            run_div(rs, ra, rb, 1'b0, $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
